// File: rtl/shift_lr_pipe.sv
// Pipelined logical/arithmetic/rotate shifter: one register stage per shift-amount
// bit, valid/ready handshake with bubble collapse, carry-out and zero flags.
module shift_lr_pipe #(
  parameter  int WIDTH = 32,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [SW-1:0]    s,
  input  logic             left,
  input  logic             log,
  input  logic             rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             zero
);

  logic [WIDTH-1:0] data_r  [SW];
  logic             valid_r [SW];
  logic             cout_r  [SW];
  logic [SW-1:0]    s_r     [SW-1];
  logic             left_r  [SW-1];
  logic             log_r   [SW-1];
  logic             rot_r   [SW-1];
  logic             zero_r;
  logic [SW-1:0]    adv_s;

  // Stage k may load whenever it is empty or its contents move on this edge.
  always_comb begin
    adv_s         = {SW{1'b0}};
    adv_s[SW-1]   = ~valid_r[SW-1] | out_ready;
    for (int k = SW - 2; k >= 0; k--) begin
      adv_s[k] = ~valid_r[k] | adv_s[k+1];
    end
  end

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int AMT = 1 << k;

    logic [WIDTH-1:0] d_in_s;
    logic [WIDTH-1:0] d_nx_s;
    logic [SW-1:0]    s_in_s;
    logic             v_in_s;
    logic             l_in_s;
    logic             g_in_s;
    logic             r_in_s;
    logic             c_in_s;
    logic             b_s;
    logic             c_nx_s;

    if (k == 0) begin : g_src
      assign d_in_s = x;
      assign s_in_s = s;
      assign v_in_s = in_valid;
      assign l_in_s = left;
      assign g_in_s = log;
      assign r_in_s = rot;
      assign c_in_s = 1'b0;
    end else begin : g_src
      assign d_in_s = data_r[k-1];
      assign s_in_s = s_r[k-1];
      assign v_in_s = valid_r[k-1];
      assign l_in_s = left_r[k-1];
      assign g_in_s = log_r[k-1];
      assign r_in_s = rot_r[k-1];
      assign c_in_s = cout_r[k-1];
    end

    // The amount travels shifted down one bit per stage, so only the last stage's
    // bit 0 can be set and the reduction equals that bit.
    if (k == SW - 1) begin : g_bit
      assign b_s = |s_in_s;
    end else begin : g_bit
      assign b_s = s_in_s[0];
    end

    // Shift/rotate by 2^k; COUT takes the last bit leaving (or wrapping) the word.
    always_comb begin
      d_nx_s = d_in_s;
      c_nx_s = c_in_s;
      if (b_s) begin
        if (l_in_s) begin
          c_nx_s = d_in_s[WIDTH-AMT];
          if (r_in_s) begin
            d_nx_s = (d_in_s << AMT) | (d_in_s >> (WIDTH - AMT));
          end else begin
            d_nx_s = d_in_s << AMT;
          end
        end else begin
          c_nx_s = d_in_s[AMT-1];
          if (r_in_s) begin
            d_nx_s = (d_in_s >> AMT) | (d_in_s << (WIDTH - AMT));
          end else if (g_in_s) begin
            d_nx_s = d_in_s >> AMT;
          end else begin
            d_nx_s = $signed(d_in_s) >>> AMT;
          end
        end
      end else begin
        d_nx_s = d_in_s;
        c_nx_s = c_in_s;
      end
    end

    // Result path register; payload only captured for real operations.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r[k] <= 1'b0;
        data_r[k]  <= {WIDTH{1'b0}};
        cout_r[k]  <= 1'b0;
      end else if (adv_s[k]) begin
        valid_r[k] <= v_in_s;
        if (v_in_s) begin
          data_r[k] <= d_nx_s;
          cout_r[k] <= c_nx_s;
        end
      end
    end

    if (k < SW - 1) begin : g_ctl
      // Control fields carried forward to the remaining stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_r[k]    <= {SW{1'b0}};
          left_r[k] <= 1'b0;
          log_r[k]  <= 1'b0;
          rot_r[k]  <= 1'b0;
        end else if (adv_s[k] && v_in_s) begin
          s_r[k]    <= s_in_s >> 1;
          left_r[k] <= l_in_s;
          log_r[k]  <= g_in_s;
          rot_r[k]  <= r_in_s;
        end
      end
    end else begin : g_zero
      // Zero flag registered alongside the final data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          zero_r <= 1'b0;
        end else if (adv_s[k] && v_in_s) begin
          zero_r <= (d_nx_s == {WIDTH{1'b0}});
        end
      end
    end
  end

  assign in_ready  = adv_s[0];
  assign out_valid = valid_r[SW-1];
  assign z         = data_r[SW-1];
  assign cout      = cout_r[SW-1];
  assign zero      = zero_r;

endmodule

// File: doc/shift_lr_pipe.md
# shift_lr_pipe

Parametrised, pipelined successor to the 32-bit combinational left/right shifter. It performs logical, arithmetic, or rotate shifts in either direction, and it reports carry-out and zero flags. It uses one register stage per shift-amount bit and a valid/ready handshake with bubble collapse, so it sustains one operation per cycle and sits between the operand-select stage and the result bus of the functional unit.

## Interface
- WIDTH, 32, data width; power of two, 4..64
- SW, log2(WIDTH), shift-amount width; derived, not overridden
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  operand valid
- IN_READY  out  1  pipeline can accept this cycle
- X  in  WIDTH  operand
- S  in  SW  shift amount, 0..WIDTH-1
- LEFT  in  1  1 = left, 0 = right
- LOG  in  1  1 = logical, 0 = arithmetic (sign fill on right shift only)
- ROT  in  1  1 = rotate; overrides LOG
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- Z  out  WIDTH  result
- COUT  out  1  last bit shifted out (or wrapped)
- ZERO  out  1  Z == 0

## Operation
- Stage k (k = 0..SW-1) shifts or rotates its input by 2^k when its registered S[k] = 1; otherwise it passes the data through.
- Each stage registers data, the remaining S bits, LEFT/LOG/ROT, the running COUT, and a valid bit.
- Fill rules:
  - Left shift fills with 0.
  - Right logical shift fills with 0.
  - Right arithmetic shift fills with X[WIDTH-1].
  - Rotate fills with the bits that leave the opposite end.
- COUT for n = S:
  - n = 0 → 0.
  - Left shift → X[WIDTH-n].
  - Right shift (logical or arithmetic) → X[n-1].
  - Rotate left → Z[0].
  - Rotate right → Z[WIDTH-1].
- A stage whose shift bit is 0 leaves COUT unchanged. A stage whose shift bit is 1 overwrites COUT with the last bit it shifts out.
- ZERO is computed from the final stage data and registered with it.
- Handshake:
  - Accept on a rising edge when IN_VALID & IN_READY.
  - Deliver on a rising edge when OUT_VALID & OUT_READY.
  - While OUT_VALID = 1 and OUT_READY = 0, Z, COUT and ZERO hold stable.
- Bubble collapse: stage k advances when ~valid_k | advance_{k+1}. The output stage advances on ~OUT_VALID | OUT_READY. IN_READY = ~valid_0 | advance_1.
- Operations never reorder, drop, or duplicate.

## Timing
- Reset (async assert, sync release): all stage valids 0, OUT_VALID 0, Z 0, COUT 0, ZERO 0. IN_READY = 1 from the first cycle after release.
- Latency: with the pipeline empty and OUT_READY = 1, OUT_VALID rises SW edges after acceptance, counting the accepting edge. For WIDTH = 32 that is 5 edges.
- Throughput: 1 operation per cycle when OUT_READY stays 1.
- Capacity: SW operations in flight.
- IN_READY = 0 only when every stage is valid and OUT_READY = 0. It is combinational from OUT_READY; no other combinational input-to-output path exists.
- Simultaneous deliver and accept on the same edge with a full pipeline: both occur and no stage is lost.
- Reset mid-operation: all in-flight operations are discarded and OUT_VALID falls immediately when RST_N is asserted. No stale result appears after release.
- S values are always < WIDTH by width, so no out-of-range case exists.

## Test plan
- Reset with IN_VALID = 1 held → OUT_VALID = 0, Z = 0 throughout. After release, IN_READY = 1 and the first accept produces exactly one result.
- WIDTH = 32, X = 0x80000010, S = 4, LEFT = 0, LOG = 0, ROT = 0 → Z = 0xF8000001, COUT = 0, ZERO = 0. OUT_VALID high at the 5th edge counting acceptance.
- X = 0x000000F1, S = 28, LEFT = 1 → Z = 0x10000000, COUT = 1. Then X = 0x00000001, S = 1, LEFT = 0, ROT = 1 → Z = 0x80000000, COUT = 1.
- X = 0x00000000, S = 0, logical right → Z = 0, ZERO = 1, COUT = 0. Then X = 0x00000001, S = 1, logical right → Z = 0, ZERO = 1, COUT = 1.
- Stream 8 back-to-back random operations with OUT_READY low for 3 cycles mid-stream:
  - all 8 results match a reference model, in order;
  - IN_READY drops only once 5 operations are held;
  - Z is stable while stalled.
- Three operations in flight, RST_N pulsed low for 1 cycle → OUT_VALID low immediately; no result emitted after release until a new accept.
